display_scan_ctrl: RTL and testbench

- Scan controller for the 4-digit multiplexed 7-segment display of the ALU board.
- Generates the 2-bit digit select AN_SEL, which drives the digit mux. The mux returns digit_BCD for that slot (Ones/Tens/Hundreds/Letters).
- Decodes digit_BCD to active-low segments and drives active-low anodes.
- Adds a guard (ghost-suppression) interval on every digit change and blanks leading zeros.

---
 rtl/display_scan_ctrl.sv | 111 +++++++++++
 tb/tb_display_scan_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller: walks AN_SEL Letters->Ones,
// inserts an all-dark guard after every digit change and blanks leading zeros.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 16,
  parameter bit          BLANK_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit_BCD,
  output logic [1:0] AN_SEL,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       frame_done
);

  localparam logic [19:0] CNT_LAST = 20'(REFRESH_DIV - 1);
  localparam logic [19:0] CNT_CAP  = 20'(GUARD - 1);

  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        fd_q, fd_d;
  logic        lz_q, lz_d;
  logic        digit_zero;
  logic        blank;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b0000011;
      4'hC:    decode = 7'b1000110;
      4'hD:    decode = 7'b0100001;
      4'hE:    decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  assign digit_zero = (digit_BCD == 4'h0);
  // Hundreds is scanned before Tens, so lz carries "hundreds was blank" forward.
  assign blank = BLANK_EN && digit_zero &&
                 ((sel_q == 2'b10) || ((sel_q == 2'b01) && lz_q));

  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    an_d  = an_q;
    seg_d = seg_q;
    fd_d  = 1'b0;
    lz_d  = lz_q;
    if (!en) begin
      cnt_d = 20'd0;
      sel_d = 2'b11;
      an_d  = 4'hF;
      seg_d = 7'h7F;
      lz_d  = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = 20'd0;
      an_d  = 4'hF;
      sel_d = sel_q - 2'd1;
      fd_d  = (sel_q == 2'b00);
    end else begin
      cnt_d = cnt_q + 20'd1;
      // Segments and anode update together so a lit digit never shows stale data.
      if (cnt_q == CNT_CAP) begin
        seg_d = blank ? 7'h7F : decode(digit_BCD);
        an_d  = ~(4'b0001 << sel_q);
        if (BLANK_EN) begin
          if (sel_q == 2'b10)      lz_d = digit_zero;
          else if (sel_q == 2'b01) lz_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 20'd0;
      sel_q <= 2'b11;
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      fd_q  <= 1'b0;
      lz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      fd_q  <= fd_d;
      lz_q  <= lz_d;
    end
  end

  assign AN_SEL     = sel_q;
  assign AN         = an_q;
  assign SEG        = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: one instance with leading-zero blanking,
// one without, both fed by a behavioural digit mux.
module tb_display_scan_ctrl;

  localparam logic [6:0] S_0  = 7'h40;
  localparam logic [6:0] S_1  = 7'h79;
  localparam logic [6:0] S_2  = 7'h24;
  localparam logic [6:0] S_3  = 7'h30;
  localparam logic [6:0] S_5  = 7'h12;
  localparam logic [6:0] S_A  = 7'h08;
  localparam logic [6:0] S_E  = 7'h06;
  localparam logic [6:0] S_BL = 7'h7F;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] digits [4];
  logic [3:0] dig_b, dig_n;
  logic [1:0] sel_b, sel_n;
  logic [3:0] an_b, an_n;
  logic [6:0] seg_b, seg_n;
  logic       fd_b, fd_n;
  int         vecs = 0;
  int         errs = 0;

  always #5 clk = ~clk;

  assign dig_b = digits[sel_b];
  assign dig_n = digits[sel_n];

  display_scan_ctrl #(.REFRESH_DIV(8), .GUARD(2), .BLANK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .digit_BCD(dig_b),
    .AN_SEL(sel_b), .AN(an_b), .SEG(seg_b), .frame_done(fd_b)
  );

  display_scan_ctrl #(.REFRESH_DIV(8), .GUARD(2), .BLANK_EN(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .en(en), .digit_BCD(dig_n),
    .AN_SEL(sel_n), .AN(an_n), .SEG(seg_n), .frame_done(fd_n)
  );

  task automatic chk(input string tag, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s k=%0d got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " an_sel"}, 0, 32'(sel_b), 32'h3);
    chk({tag, " an"},     0, 32'(an_b),  32'hF);
    chk({tag, " seg"},    0, 32'(seg_b), 32'h7F);
    chk({tag, " fd"},     0, 32'(fd_b),  32'h0);
    chk({tag, " nb an"},  0, 32'(an_n),  32'hF);
    chk({tag, " nb seg"}, 0, 32'(seg_n), 32'h7F);
  endtask

  // One full frame from cnt=0 in the Letters slot; expected SEG per slot
  // (Letters, Hundreds, Tens, Ones) for each instance.
  task automatic check_frame(input string tag,
                             input logic [6:0] b3, b2, b1, b0,
                             input logic [6:0] n3, n2, n1, n0,
                             input logic [6:0] b_start, n_start,
                             input logic fd_first);
    logic [6:0] bv [5];
    logic [6:0] nv [5];
    int         slot, c;
    logic [1:0] e_sel;
    logic [3:0] e_an;
    bv[0] = b_start; bv[1] = b3; bv[2] = b2; bv[3] = b1; bv[4] = b0;
    nv[0] = n_start; nv[1] = n3; nv[2] = n2; nv[3] = n1; nv[4] = n0;
    for (int k = 0; k < 32; k++) begin
      slot  = k / 8;
      c     = k % 8;
      e_sel = 2'(3 - slot);
      e_an  = (c < 2) ? 4'hF : ~(4'b0001 << e_sel);
      chk({tag, " an_sel"},    k, 32'(sel_b), 32'(e_sel));
      chk({tag, " an"},        k, 32'(an_b),  32'(e_an));
      chk({tag, " seg"},       k, 32'(seg_b), 32'((c < 2) ? bv[slot] : bv[slot + 1]));
      chk({tag, " fd"},        k, 32'(fd_b),  32'((k == 0) ? fd_first : 1'b0));
      chk({tag, " nb an_sel"}, k, 32'(sel_n), 32'(e_sel));
      chk({tag, " nb an"},     k, 32'(an_n),  32'(e_an));
      chk({tag, " nb seg"},    k, 32'(seg_n), 32'((c < 2) ? nv[slot] : nv[slot + 1]));
      chk({tag, " nb fd"},     k, 32'(fd_n),  32'((k == 0) ? fd_first : 1'b0));
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    digits[0] = 4'd3; digits[1] = 4'd2; digits[2] = 4'd1; digits[3] = 4'hA;
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    check_frame("scan", S_A, S_1, S_2, S_3, S_A, S_1, S_2, S_3, S_BL, S_BL, 1'b0);

    digits[0] = 4'd0; digits[1] = 4'd0; digits[2] = 4'd0;
    check_frame("lz_all0", S_A, S_BL, S_BL, S_0, S_A, S_0, S_0, S_0, S_3, S_3, 1'b1);

    digits[1] = 4'd5;
    check_frame("lz_h0t5", S_A, S_BL, S_5, S_0, S_A, S_0, S_5, S_0, S_0, S_0, 1'b1);

    digits[0] = 4'hE; digits[1] = 4'd0; digits[2] = 4'd1;
    check_frame("h1t0", S_A, S_1, S_0, S_E, S_A, S_1, S_0, S_E, S_0, S_0, 1'b1);

    // Drop enable at cnt=5 of the Tens slot.
    for (int i = 0; i < 21; i++) cycle();
    chk("en_pre an_sel", 0, 32'(sel_b), 32'h1);
    chk("en_pre an",     0, 32'(an_b),  32'hD);
    en = 1'b0;
    cycle();
    chk("en_off an_sel", 1, 32'(sel_b), 32'h3);
    chk("en_off an",     1, 32'(an_b),  32'hF);
    chk("en_off seg",    1, 32'(seg_b), 32'h7F);
    chk("en_off fd",     1, 32'(fd_b),  32'h0);
    cycle();
    chk("en_hold an",    2, 32'(an_b),  32'hF);
    chk("en_hold seg",   2, 32'(seg_b), 32'h7F);
    en = 1'b1;
    check_frame("reen", S_A, S_1, S_0, S_E, S_A, S_1, S_0, S_E, S_BL, S_BL, 1'b0);

    // Asynchronous reset between edges while the Hundreds digit is lit.
    for (int i = 0; i < 10; i++) cycle();
    chk("pre_rst an",  0, 32'(an_b),  32'hB);
    chk("pre_rst seg", 0, 32'(seg_b), 32'(S_1));
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    @(negedge clk);
    rst = 1'b0;
    check_frame("post_rst", S_A, S_1, S_0, S_E, S_A, S_1, S_0, S_E, S_BL, S_BL, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
